md5core_input_loader: RTL and testbench

- Upstream feeder for the type-2 MD5 core's input buffer. It has 4 slots, indexed {ctx,seq}.
- Accepts a block descriptor (ctx, seq, blk_op, word count) plus a 32-bit word stream.
- Waits until the target slot reports ready, then writes exactly 16 words at wr_addr 0..15, zero-padding past the supplied count.
- Marks the block valid via set_input_ready on the 16th write.

---
 rtl/md5core_input_loader_pkg.sv | 29 ++
 rtl/md5core_input_loader.sv | 98 +++++++++
 tb/tb_md5core_input_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/md5core_input_loader_pkg.sv
// Shared constants for the MD5 core input loader: block-op encoding, block size,
// ready-mask slot ordering and descriptor-length clamping.
package md5core_input_loader_pkg;

  localparam int BLK_OP_MSB   = 3;
  localparam int BLK_OP_WIDTH = BLK_OP_MSB + 1;

  localparam logic [BLK_OP_MSB:0] BLK_OP_FIRST = 4'd0;
  localparam logic [BLK_OP_MSB:0] BLK_OP_MID   = 4'd1;
  localparam logic [BLK_OP_MSB:0] BLK_OP_LAST  = 4'd2;
  localparam logic [BLK_OP_MSB:0] BLK_OP_ONLY  = 4'd3;

  localparam int             MAX_WORDS = 16;
  localparam int             LEN_W     = 5;
  localparam logic [LEN_W-1:0] MAX_LEN = 5'd16;
  localparam logic [3:0]     LAST_ADDR = 4'd15;

  typedef enum logic {S_IDLE, S_LOAD} ld_state_t;

  // Core ready mask is indexed {ctx,seq}
  function automatic logic [1:0] slot_idx(input logic ctx, input logic seq);
    return {ctx, seq};
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/md5core_input_loader.sv
// Feeds one 16-word block into a ready slot of the MD5 core input buffer,
// zero-padding past the supplied word count and flagging the slot on the last write.
module md5core_input_loader #(
  parameter int BLK_OP_W = md5core_input_loader_pkg::BLK_OP_WIDTH
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic                desc_valid,
  input  logic                desc_ctx,
  input  logic                desc_seq,
  input  logic [BLK_OP_W-1:0] desc_blk_op,
  input  logic [4:0]          desc_len,
  output logic                desc_rd,
  input  logic [31:0]         src_data,
  input  logic                src_valid,
  output logic                src_rd,
  input  logic [3:0]          core_ready,
  output logic                wr_en,
  output logic [31:0]         din,
  output logic [3:0]          wr_addr,
  output logic [BLK_OP_W-1:0] input_blk_op,
  output logic                input_ctx,
  output logic                input_seq,
  output logic                set_input_ready,
  output logic                busy
);
  import md5core_input_loader_pkg::*;

  ld_state_t        state, state_nxt;
  logic [3:0]       cnt;
  logic [LEN_W-1:0] len_q;
  logic             in_data;
  logic             wr_nxt;
  logic [31:0]      din_nxt;

  assign in_data = ({1'b0, cnt} < len_q);
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    desc_rd   = 1'b0;
    src_rd    = 1'b0;
    wr_nxt    = 1'b0;
    din_nxt   = '0;
    unique case (state)
      S_IDLE: begin
        if (desc_valid && core_ready[slot_idx(desc_ctx, desc_seq)]) begin
          desc_rd   = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // Past the supplied count the word is padding and needs no source data
        if (!in_data) begin
          wr_nxt = 1'b1;
        end else if (src_valid) begin
          src_rd  = 1'b1;
          wr_nxt  = 1'b1;
          din_nxt = src_data;
        end
        if (wr_nxt && (cnt == LAST_ADDR)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      len_q           <= '0;
      wr_en           <= 1'b0;
      din             <= '0;
      wr_addr         <= '0;
      set_input_ready <= 1'b0;
      input_ctx       <= 1'b0;
      input_seq       <= 1'b0;
      input_blk_op    <= '0;
    end else begin
      state           <= state_nxt;
      wr_en           <= wr_nxt;
      din             <= din_nxt;
      set_input_ready <= wr_nxt && (cnt == LAST_ADDR);
      if (wr_nxt) begin
        wr_addr <= cnt;
        cnt     <= cnt + 4'd1;
      end
      if (desc_rd) begin
        input_ctx    <= desc_ctx;
        input_seq    <= desc_seq;
        input_blk_op <= desc_blk_op;
        len_q        <= clamp_len(desc_len);
        cnt          <= '0;
      end
    end
  end

endmodule

// File: tb/tb_md5core_input_loader.sv
// Directed and randomized block loads checked against a per-block model of the
// expected 16-word write image.
module tb_md5core_input_loader;
  import md5core_input_loader_pkg::*;
  localparam int OPW = BLK_OP_WIDTH;

  logic           CLK = 1'b0;
  logic           rst_n = 1'b0;
  logic           desc_valid = 1'b0, desc_ctx = 1'b0, desc_seq = 1'b0;
  logic [OPW-1:0] desc_blk_op = '0;
  logic [4:0]     desc_len = '0;
  logic           desc_rd;
  logic [31:0]    src_data = '0;
  logic           src_valid = 1'b0;
  logic           src_rd;
  logic [3:0]     core_ready = 4'b1111;
  logic           wr_en;
  logic [31:0]    din;
  logic [3:0]     wr_addr;
  logic [OPW-1:0] input_blk_op;
  logic           input_ctx, input_seq, set_input_ready, busy;

  always #5 CLK = ~CLK;

  md5core_input_loader dut (
    .CLK(CLK), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ctx(desc_ctx), .desc_seq(desc_seq),
    .desc_blk_op(desc_blk_op), .desc_len(desc_len), .desc_rd(desc_rd),
    .src_data(src_data), .src_valid(src_valid), .src_rd(src_rd),
    .core_ready(core_ready), .wr_en(wr_en), .din(din), .wr_addr(wr_addr),
    .input_blk_op(input_blk_op), .input_ctx(input_ctx), .input_seq(input_seq),
    .set_input_ready(set_input_ready), .busy(busy)
  );

  int n_cmp = 0, n_err = 0;
  logic [31:0] src_q[$];
  int valid_pct = 100, stall_at = -1, stall_len = 0, stall_left = 0, pops = 0;
  logic rd_seen, drd_seen;
  bit in_blk = 0;
  int nwr, cyc = 0, first_cyc, last_cyc, acc_cyc;
  logic [31:0] exp_w[16];
  logic b_ctx, b_seq;
  logic [OPW-1:0] b_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    if (stall_left > 0) begin
      src_valid = 1'b0;
      stall_left--;
    end else begin
      src_valid = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
    end
    src_data = (src_q.size() > 0) ? src_q[0] : 32'hDEAD_BEEF;
  endtask

  // One clock: sample combinational pulses mid-cycle, then registered outputs after the edge
  task automatic step();
    @(negedge CLK);
    rd_seen  = src_rd;
    drd_seen = desc_rd;
    chk("src_rd_without_valid", 32'(src_rd & ~src_valid), 32'd0);
    @(posedge CLK);
    #1;
    cyc++;
    if (rd_seen) begin
      void'(src_q.pop_front());
      pops++;
      if (pops == stall_at) stall_left = stall_len;
    end
    chk("sir_without_wr", 32'(set_input_ready & ~wr_en), 32'd0);
    if (wr_en) begin
      if (!in_blk || nwr >= 16) begin
        chk("stray_wr", 32'(wr_en), 32'(in_blk && nwr < 16));
      end else begin
        chk("wr_addr", 32'(wr_addr), 32'(nwr));
        chk("din", din, exp_w[nwr]);
        chk("input_ctx", 32'(input_ctx), 32'(b_ctx));
        chk("input_seq", 32'(input_seq), 32'(b_seq));
        chk("set_input_ready", 32'(set_input_ready), 32'(nwr == 15));
        if (nwr == 15) chk("input_blk_op", 32'(input_blk_op), 32'(b_op));
        if (nwr == 0) first_cyc = cyc;
        last_cyc = cyc;
        nwr++;
      end
    end
    drive_src();
  endtask

  // base!=0 gives base+k source words, else random; rst_at>=0 resets after that address is written
  task automatic run_block(input logic ctx, input logic seq, input logic [OPW-1:0] op,
                           input int len, input logic [31:0] base, input int pct,
                           input int st_at, input int st_len, input int exp_span,
                           input int rst_at);
    logic [31:0] w;
    int clamp;
    clamp = (len > MAX_WORDS) ? MAX_WORDS : len;
    for (int a = 0; a < 16; a++) exp_w[a] = 32'd0;
    for (int k = 0; k < len; k++) begin
      w = (base != 0) ? base + 32'(k) : $urandom;
      src_q.push_back(w);
      if (k < clamp) exp_w[k] = w;
    end
    valid_pct = pct; stall_at = st_at; stall_len = st_len; stall_left = 0; pops = 0;
    b_ctx = ctx; b_seq = seq; b_op = op; nwr = 0; in_blk = 1;
    drive_src();
    desc_ctx = ctx; desc_seq = seq; desc_blk_op = op; desc_len = 5'(len); desc_valid = 1'b1;
    step();
    chk("desc_rd_accept", 32'(drd_seen), 32'd1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    acc_cyc = cyc;
    desc_valid = 1'b0;
    for (int c = 0; c < 400 && nwr < 16; c++) begin
      if (rst_at >= 0 && nwr == rst_at + 1) break;
      step();
      chk("desc_rd_single", 32'(drd_seen), 32'd0);
    end
    if (rst_at >= 0) begin
      in_blk = 0;
      rst_n = 1'b0;
      step();
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sir", 32'(set_input_ready), 32'd0);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
        step();
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);
        chk("post_rst_desc_rd", 32'(drd_seen), 32'd0);
      end
    end else begin
      chk("n_writes", 32'(nwr), 32'd16);
      chk("src_pops", 32'(pops), 32'(clamp));
      chk("src_leftover", 32'(src_q.size()), 32'(len - clamp));
      chk("busy_end", 32'(busy), 32'd0);
      if (pct == 100 || clamp == 0) chk("first_wr_latency", 32'(first_cyc - acc_cyc), 32'd1);
      if (exp_span > 0) chk("write_span", 32'(last_cyc - first_cyc + 1), 32'(exp_span));
    end
    in_blk = 0;
    src_q.delete();
    stall_at = -1;
    drive_src();
  endtask

  initial begin
    logic c, s;
    logic [OPW-1:0] o;
    int l, p;
    rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_desc_rd", 32'(desc_rd), 32'd0);
    chk("rst_src_rd", 32'(src_rd), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_sir", 32'(set_input_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_ctx_seq", 32'({input_ctx, input_seq}), 32'd0);
    chk("rst_blk_op", 32'(input_blk_op), 32'd0);
    rst_n = 1'b1;

    run_block(1'b1, 1'b0, BLK_OP_ONLY, 16, 32'h1000, 100, -1, 0, 16, -1);
    run_block(1'b0, 1'b1, BLK_OP_LAST, 14, 32'hA0, 100, -1, 0, 16, -1);
    run_block(1'b0, 1'b0, BLK_OP_MID, 16, 32'h0, 100, 6, 3, 19, -1);

    // Slot {1,0} not ready: loader must sit idle
    core_ready = 4'b1011;
    desc_ctx = 1'b1; desc_seq = 1'b0; desc_blk_op = BLK_OP_FIRST; desc_len = 5'd16;
    desc_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("gated_desc_rd", 32'(drd_seen), 32'd0);
      chk("gated_wr_en", 32'(wr_en), 32'd0);
      chk("gated_busy", 32'(busy), 32'd0);
    end
    core_ready = 4'b1111;
    run_block(1'b1, 1'b0, BLK_OP_FIRST, 16, 32'h0, 100, -1, 0, 16, -1);

    run_block(1'b1, 1'b1, BLK_OP_LAST, 16, 32'h0, 100, -1, 0, 0, 7);
    run_block(1'b1, 1'b1, BLK_OP_LAST, 10, 32'h0, 100, -1, 0, 16, -1);

    run_block(1'b0, 1'b0, BLK_OP_ONLY, 0, 32'h0, 100, -1, 0, 16, -1);
    run_block(1'b0, 1'b1, BLK_OP_FIRST, 20, 32'h5000, 100, -1, 0, 16, -1);

    for (int b = 0; b < 12; b++) begin
      c = 1'($urandom_range(1));
      s = 1'($urandom_range(1));
      o = OPW'($urandom_range(15));
      l = $urandom_range(20);
      p = (b < 4) ? 100 : 40 + $urandom_range(60);
      run_block(c, s, o, l, 32'h0, p, -1, 0, (p == 100) ? 16 : 0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
